// File: rtl/wb_counter_bank.sv
// Wishbone-mapped bank of CHANNELS up/down counters with limit, one-shot mode and sticky TC interrupt.
// Optional per-channel 8-bit prescaler when PRESCALER_EN is defined.
module wb_counter_bank #(
   parameter int BITS     = 16,
   parameter int CHANNELS = 4
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       wbs_cyc_i,
   input  logic                       wbs_stb_i,
   input  logic                       wbs_we_i,
   input  logic [3:0]                 wbs_sel_i,
   input  logic [31:0]                wbs_adr_i,
   input  logic [31:0]                wbs_dat_i,
   output logic                       wbs_ack_o,
   output logic [31:0]                wbs_dat_o,
   input  logic [CHANNELS-1:0]        la_wr_i,
   input  logic [BITS-1:0]            la_val_i,
   output logic [CHANNELS*BITS-1:0]   count_o,
   output logic [CHANNELS-1:0]        irq_o
);

   logic        fire;
   logic [1:0]  ch;
   logic [1:0]  rg;
   logic [31:0] rd_word [4];
   logic        unused_bits;

   // A request is accepted only while ack is low, giving one ack every other cycle.
   assign fire        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign ch          = wbs_adr_i[5:4];
   assign rg          = wbs_adr_i[3:2];
   assign unused_bits = ^{wbs_adr_i[31:6], wbs_adr_i[1:0], wbs_dat_i};

   function automatic logic [BITS-1:0] lane_merge(input logic [BITS-1:0] old,
                                                  input logic [31:0]     d,
                                                  input logic [3:0]      sel);
      logic [BITS-1:0] r;
      for (int i = 0; i < BITS; i++)
         r[i] = sel[i/8] ? d[i] : old[i];
      return r;
   endfunction

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= fire;
         if (fire)
            wbs_dat_o <= wbs_we_i ? '0 : rd_word[ch];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_ch
      if (c < CHANNELS) begin : g_on
         logic [BITS-1:0] count, limit;
         logic            en, dir, oneshot, irq_en, tc;
         logic            wr, wr_ctrl, wr_count, wr_limit, wr_stat;
         logic            tick, at_term;
         logic [7:0]      presc_rd;
         logic [31:0]     ctrl_word;

         assign wr       = fire & wbs_we_i & (ch == 2'(c));
         assign wr_ctrl  = wr & (rg == 2'd0);
         assign wr_count = wr & (rg == 2'd1);
         assign wr_limit = wr & (rg == 2'd2);
         assign wr_stat  = wr & (rg == 2'd3);
         assign at_term  = dir ? (count == '0) : (count == limit);

`ifdef PRESCALER_EN
         logic [7:0] presc, psc;
         assign presc_rd = presc;
         assign tick     = en & (psc == presc);

         always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
               presc <= '0;
               psc   <= '0;
            end else begin
               if (wr_ctrl && wbs_sel_i[1])
                  presc <= wbs_dat_i[15:8];
               if (wr_ctrl || wr_count || !en || psc == presc)
                  psc <= '0;
               else
                  psc <= psc + 8'd1;
            end
         end
`else
         assign presc_rd = 8'd0;
         assign tick     = en;
`endif

         assign ctrl_word = {16'd0, presc_rd, 4'd0, irq_en, oneshot, dir, en};

         always_comb begin
            rd_word[c] = '0;
            case (rg)
               2'd0: rd_word[c] = ctrl_word;
               2'd1: rd_word[c] = 32'(count);
               2'd2: rd_word[c] = 32'(limit);
               2'd3: rd_word[c] = {30'd0, en, tc};
            endcase
         end

         always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
               count   <= '0;
               limit   <= '1;
               en      <= 1'b0;
               dir     <= 1'b0;
               oneshot <= 1'b0;
               irq_en  <= 1'b0;
               tc      <= 1'b0;
            end else begin
               if (wr_ctrl && wbs_sel_i[0])
                  {irq_en, oneshot, dir, en} <= wbs_dat_i[3:0];
               if (wr_limit)
                  limit <= lane_merge(limit, wbs_dat_i, wbs_sel_i);
               if (wr_stat && wbs_sel_i[0] && wbs_dat_i[0])
                  tc <= 1'b0;
               // Writes to COUNT/CTRL and LA loads discard the step; a TC set
               // below overrides a same-cycle W1C.
               if (wr_count)
                  count <= lane_merge(count, wbs_dat_i, wbs_sel_i);
               else if (la_wr_i[c])
                  count <= la_val_i;
               else if (tick && !wr_ctrl) begin
                  if (at_term) begin
                     tc <= 1'b1;
                     if (oneshot)
                        en <= 1'b0;
                     else
                        count <= dir ? limit : '0;
                  end else begin
                     count <= dir ? count - 1'b1 : count + 1'b1;
                  end
               end
            end
         end

         assign count_o[c*BITS +: BITS] = count;
         assign irq_o[c]                = tc & irq_en;
      end else begin : g_off
         assign rd_word[c] = '0;
      end
   end

endmodule

// File: tb/tb_wb_counter_bank.sv
// Directed bench for wb_counter_bank (BITS=16, CHANNELS=3): register table plus counting sequences.
module tb_wb_counter_bank;

   localparam int BITS = 16;
   localparam int CH   = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]        sel = 4'h0;
   logic [31:0]       adr = '0, dat_i = '0;
   logic              ack;
   logic [31:0]       dat_o;
   logic [CH-1:0]     la_wr = '0;
   logic [BITS-1:0]   la_val = '0;
   logic [CH*BITS-1:0] count;
   logic [CH-1:0]     irq;

   int passed = 0;
   int total  = 0;

   wb_counter_bank #(.BITS(BITS), .CHANNELS(CH)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .la_wr_i(la_wr), .la_val_i(la_val), .count_o(count), .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else passed++;
   endtask

   // Any ack must be exactly one cycle wide.
   logic ack_q = 1'b0;
   always @(negedge clk) begin
      if (ack) begin
         total++;
         if (ack_q) $display("FAIL ack_width: ack high 2 cycles, expected 1");
         else passed++;
      end
      ack_q = ack;
   end

   function automatic logic [BITS-1:0] cnt(input int c);
      return count[c*BITS +: BITS];
   endfunction

   // Returns 1ns after the ack edge with the bus released.
   task automatic xfer(input logic [1:0] c, input logic [1:0] r, input logic w,
                       input logic [3:0] s, input logic [31:0] d, output logic [31:0] q);
      int n = 0;
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_i = d;
      adr = {26'd0, c, r, 2'b00};
      do begin
         @(posedge clk); #1; n++;
      end while (!ack && n < 4);
      check("ack_seen", {31'd0, ack}, 32'd1);
      q = dat_o;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [1:0] c, input logic [1:0] r, input logic [31:0] d);
      logic [31:0] q;
      xfer(c, r, 1'b1, 4'hF, d, q);
   endtask

   task automatic rd(input logic [1:0] c, input logic [1:0] r, input logic [31:0] exp, input string name);
      logic [31:0] q;
      xfer(c, r, 1'b0, 4'hF, 32'd0, q);
      check(name, q, exp);
   endtask

   task automatic step_check(input int c, input logic [BITS-1:0] exp, input string name);
      @(posedge clk); #1;
      check(name, 32'(cnt(c)), 32'(exp));
   endtask

   typedef struct {
      logic [1:0]  c;
      logic [1:0]  r;
      logic        w;
      logic [3:0]  s;
      logic [31:0] d;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t tbl [16];

   initial begin
      logic [31:0] q;

      tbl[0]  = '{2'd0, 2'd0, 1'b0, 4'hF, 32'h0,        32'h0,    "rst_ctrl"};
      tbl[1]  = '{2'd0, 2'd1, 1'b0, 4'hF, 32'h0,        32'h0,    "rst_count"};
      tbl[2]  = '{2'd0, 2'd2, 1'b0, 4'hF, 32'h0,        32'hFFFF, "rst_limit"};
      tbl[3]  = '{2'd0, 2'd3, 1'b0, 4'hF, 32'h0,        32'h0,    "rst_status"};
      tbl[4]  = '{2'd0, 2'd1, 1'b1, 4'hF, 32'h1234,     32'h0,    ""};
      tbl[5]  = '{2'd0, 2'd1, 1'b1, 4'h2, 32'hAB00,     32'h0,    ""};
      tbl[6]  = '{2'd0, 2'd1, 1'b0, 4'hF, 32'h0,        32'hAB34, "byte_lane"};
      tbl[7]  = '{2'd0, 2'd2, 1'b1, 4'hF, 32'h12345678, 32'h0,    ""};
      tbl[8]  = '{2'd0, 2'd2, 1'b0, 4'hF, 32'h0,        32'h5678, "limit_trunc"};
      tbl[9]  = '{2'd3, 2'd1, 1'b1, 4'hF, 32'h7777,     32'h0,    ""};
      tbl[10] = '{2'd3, 2'd1, 1'b0, 4'hF, 32'h0,        32'h0,    "ch3_count"};
      tbl[11] = '{2'd3, 2'd0, 1'b0, 4'hF, 32'h0,        32'h0,    "ch3_ctrl"};
      tbl[12] = '{2'd0, 2'd1, 1'b0, 4'hF, 32'h0,        32'hAB34, "ch0_after_ch3"};
      tbl[13] = '{2'd0, 2'd0, 1'b1, 4'hF, 32'hFF0E,     32'h0,    ""};
`ifdef PRESCALER_EN
      tbl[14] = '{2'd0, 2'd0, 1'b0, 4'hF, 32'h0,        32'hFF0E, "ctrl_rb"};
`else
      tbl[14] = '{2'd0, 2'd0, 1'b0, 4'hF, 32'h0,        32'h000E, "ctrl_rb"};
`endif
      tbl[15] = '{2'd0, 2'd0, 1'b1, 4'hF, 32'h0,        32'h0,    ""};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_dat", dat_o, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_count_o", count[31:0], 32'd0);

      for (int i = 0; i < 16; i++) begin
         xfer(tbl[i].c, tbl[i].r, tbl[i].w, tbl[i].s, tbl[i].d, q);
         if (!tbl[i].w) check(tbl[i].name, q, tbl[i].exp);
      end

      // Ch1 periodic up count to LIMIT=3 with interrupt.
      wr(2'd1, 2'd2, 32'd3);
      wr(2'd1, 2'd0, 32'h9);
      check("c1_s0", 32'(cnt(1)), 32'd0);
      step_check(1, 16'd1, "c1_s1");
      step_check(1, 16'd2, "c1_s2");
      step_check(1, 16'd3, "c1_s3");
      check("c1_irq_pre", 32'(irq[1]), 32'd0);
      step_check(1, 16'd0, "c1_wrap");
      check("c1_irq", 32'(irq[1]), 32'd1);
      wr(2'd1, 2'd3, 32'd1);
      check("c1_w1c", 32'(irq[1]), 32'd0);
      wr(2'd1, 2'd0, 32'd0);

      // Ch2 one-shot down count.
      wr(2'd2, 2'd1, 32'd2);
      wr(2'd2, 2'd0, 32'h7);
      check("c2_s0", 32'(cnt(2)), 32'd2);
      step_check(2, 16'd1, "c2_s1");
      step_check(2, 16'd0, "c2_s2");
      step_check(2, 16'd0, "c2_hold1");
      step_check(2, 16'd0, "c2_hold2");
      rd(2'd2, 2'd3, 32'h1, "c2_status");
      rd(2'd2, 2'd0, 32'h6, "c2_ctrl");
      check("c2_irq", 32'(irq[2]), 32'd0);

      // Ch2 periodic down count reloads LIMIT.
      wr(2'd2, 2'd2, 32'd2);
      wr(2'd2, 2'd1, 32'd0);
      wr(2'd2, 2'd0, 32'h3);
      check("c2d_s0", 32'(cnt(2)), 32'd0);
      step_check(2, 16'd2, "c2d_reload");
      step_check(2, 16'd1, "c2d_s2");
      step_check(2, 16'd0, "c2d_s3");
      step_check(2, 16'd2, "c2d_reload2");
      wr(2'd2, 2'd0, 32'd0);

      // Ch0 LA force-load and WB-vs-LA priority.
      wr(2'd0, 2'd2, 32'hFFFF);
      wr(2'd0, 2'd1, 32'd0);
      wr(2'd0, 2'd0, 32'h1);
      check("c0_s0", 32'(cnt(0)), 32'd0);
      la_wr = 3'b001; la_val = 16'h1234;
      step_check(0, 16'h1234, "la_load");
      la_wr = 3'b000;
      step_check(0, 16'h1235, "la_then_step");
      la_wr = 3'b001;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; dat_i = 32'h55;
      adr = {26'd0, 2'd0, 2'd1, 2'b00};
      @(posedge clk); #1;
      check("prio_ack", {31'd0, ack}, 32'd1);
      check("wb_beats_la", 32'(cnt(0)), 32'h55);
      la_wr = 3'b000; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      step_check(0, 16'h56, "prio_step");

`ifdef PRESCALER_EN
      wr(2'd0, 2'd0, 32'h0);
      wr(2'd0, 2'd1, 32'h10);
      wr(2'd0, 2'd0, 32'h0201);
      step_check(0, 16'h10, "psc_c1");
      step_check(0, 16'h10, "psc_c2");
      step_check(0, 16'h11, "psc_c3");
      step_check(0, 16'h11, "psc_c4");
      step_check(0, 16'h11, "psc_c5");
      step_check(0, 16'h12, "psc_c6");
`endif

      // Reset during a pending request drops it.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_ack", {31'd0, ack}, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      check("rst_mid_count", count[31:0], 32'd0);
      rd(2'd0, 2'd2, 32'hFFFF, "rst_mid_limit");

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
